// File: rtl/dat_read_sequencer.sv
// rtl/dat_read_sequencer.sv - DAT-line read transfer sequencer for the SDHCI data path
//
// Sequences single- and multi-block reads: enables the data-timeout counter
// only while waiting for a start bit, counts good blocks, pauses the SD clock
// (read-wait) when the host buffer is full, and handles stop-at-block-gap.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 begin a read transfer (ignored while busy)
//   multi_block_i           multi-block transfer (sampled at start)
//   block_count_en_i        block count limits transfer (sampled at start)
//   block_count_i           number of blocks to read (sampled at start)
//   stop_at_gap_i           level: stop at the next block gap
//   continue_i              resume from STOPPED
//   abort_i                 abort to IDLE, overrides everything
//   buffer_ready_i          host buffer can accept another block
//   rx_start_bit_i          receiver saw a start bit
//   rx_done_i, rx_crc_ok_i  receiver finished a block, with CRC status
//   timeout_i               data timeout reached
//   timeout_running_o       enables/clears the external timeout counter
//   busy_o                  transfer active
//   clk_pause_o             read-wait: stop SD clock
//   blocks_done_o           good blocks received this transfer
//   xfer_complete_o, block_gap_event_o, timeout_err_o, crc_err_o   1-cycle events

module dat_read_sequencer #(
    parameter int BLOCK_COUNT_WIDTH = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic                         multi_block_i,
    input  logic                         block_count_en_i,
    input  logic [BLOCK_COUNT_WIDTH-1:0] block_count_i,
    input  logic                         stop_at_gap_i,
    input  logic                         continue_i,
    input  logic                         abort_i,
    input  logic                         buffer_ready_i,
    input  logic                         rx_start_bit_i,
    input  logic                         rx_done_i,
    input  logic                         rx_crc_ok_i,
    input  logic                         timeout_i,
    output logic                         timeout_running_o,
    output logic                         busy_o,
    output logic                         clk_pause_o,
    output logic [BLOCK_COUNT_WIDTH-1:0] blocks_done_o,
    output logic                         xfer_complete_o,
    output logic                         block_gap_event_o,
    output logic                         timeout_err_o,
    output logic                         crc_err_o
);

    localparam logic [BLOCK_COUNT_WIDTH-1:0] ONE = {{(BLOCK_COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        RECEIVE,
        GAP,
        STOPPED
    } state_t;

    state_t                         state;
    logic [BLOCK_COUNT_WIDTH-1:0]   target;
    logic                           unlimited;
    logic [BLOCK_COUNT_WIDTH-1:0]   done_inc;

    assign done_inc = blocks_done_o + ONE;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= IDLE;
            target            <= '0;
            unlimited         <= 1'b0;
            timeout_running_o <= 1'b0;
            busy_o            <= 1'b0;
            clk_pause_o       <= 1'b0;
            blocks_done_o     <= '0;
            xfer_complete_o   <= 1'b0;
            block_gap_event_o <= 1'b0;
            timeout_err_o     <= 1'b0;
            crc_err_o         <= 1'b0;
        end else begin
            xfer_complete_o   <= 1'b0;
            block_gap_event_o <= 1'b0;
            timeout_err_o     <= 1'b0;
            crc_err_o         <= 1'b0;

            if (abort_i) begin
                // blocks_done_o deliberately left untouched so software can read it
                state             <= IDLE;
                timeout_running_o <= 1'b0;
                clk_pause_o       <= 1'b0;
                busy_o            <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            if (multi_block_i && block_count_en_i && (block_count_i == '0)) begin
                                xfer_complete_o <= 1'b1;
                            end else begin
                                state             <= WAIT_START;
                                target            <= multi_block_i ? block_count_i : ONE;
                                unlimited         <= multi_block_i && !block_count_en_i;
                                blocks_done_o     <= '0;
                                timeout_running_o <= 1'b1;
                                busy_o            <= 1'b1;
                            end
                        end
                    end
                    WAIT_START: begin
                        // A start bit in the same cycle as the timeout still wins
                        if (rx_start_bit_i) begin
                            state             <= RECEIVE;
                            timeout_running_o <= 1'b0;
                        end else if (timeout_i) begin
                            state             <= IDLE;
                            timeout_err_o     <= 1'b1;
                            timeout_running_o <= 1'b0;
                            busy_o            <= 1'b0;
                        end
                    end
                    RECEIVE: begin
                        if (rx_done_i) begin
                            if (!rx_crc_ok_i) begin
                                state     <= IDLE;
                                crc_err_o <= 1'b1;
                                busy_o    <= 1'b0;
                            end else begin
                                if (!(unlimited && (&blocks_done_o)))
                                    blocks_done_o <= done_inc;
                                if (!unlimited && (done_inc == target)) begin
                                    state           <= IDLE;
                                    xfer_complete_o <= 1'b1;
                                    busy_o          <= 1'b0;
                                end else begin
                                    state <= GAP;
                                end
                            end
                        end
                    end
                    GAP: begin
                        // Always at least one cycle here so the timeout counter clears
                        if (!buffer_ready_i) begin
                            clk_pause_o <= 1'b1;
                        end else if (stop_at_gap_i) begin
                            state             <= STOPPED;
                            block_gap_event_o <= 1'b1;
                            clk_pause_o       <= 1'b1;
                        end else begin
                            state             <= WAIT_START;
                            clk_pause_o       <= 1'b0;
                            timeout_running_o <= 1'b1;
                        end
                    end
                    STOPPED: begin
                        if (continue_i) begin
                            state             <= WAIT_START;
                            clk_pause_o       <= 1'b0;
                            timeout_running_o <= 1'b1;
                        end
                    end
                    default: begin
                        state             <= IDLE;
                        timeout_running_o <= 1'b0;
                        clk_pause_o       <= 1'b0;
                        busy_o            <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dat_read_sequencer.sv
// tb/tb_dat_read_sequencer.sv - directed scoreboard bench for dat_read_sequencer

module tb_dat_read_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 0, multi_block = 0, block_count_en = 0;
    logic [15:0] block_count = '0;
    logic        stop_at_gap = 0, continue_s = 0, abort_s = 0, buffer_ready = 1;
    logic        rx_start_bit = 0, rx_done = 0, rx_crc_ok = 0, timeout = 0;
    logic        timeout_running, busy, clk_pause;
    logic [15:0] blocks_done;
    logic        xfer_complete, block_gap_event, timeout_err, crc_err;

    int passed = 0;
    int total  = 0;

    // Expected events: {complete, gap, timeout_err, crc_err, blocks_done[15:0]}
    logic [19:0] sb[$];
    logic [19:0] exp_ev;
    logic [3:0]  obs_kind;

    localparam logic [3:0] EV_CMP = 4'b1000, EV_GAP = 4'b0100, EV_TO = 4'b0010, EV_CRC = 4'b0001;

    dat_read_sequencer #(.BLOCK_COUNT_WIDTH(16)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .multi_block_i(multi_block),
        .block_count_en_i(block_count_en), .block_count_i(block_count),
        .stop_at_gap_i(stop_at_gap), .continue_i(continue_s), .abort_i(abort_s),
        .buffer_ready_i(buffer_ready), .rx_start_bit_i(rx_start_bit), .rx_done_i(rx_done),
        .rx_crc_ok_i(rx_crc_ok), .timeout_i(timeout), .timeout_running_o(timeout_running),
        .busy_o(busy), .clk_pause_o(clk_pause), .blocks_done_o(blocks_done),
        .xfer_complete_o(xfer_complete), .block_gap_event_o(block_gap_event),
        .timeout_err_o(timeout_err), .crc_err_o(crc_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Every event pulse is popped against the scoreboard at the falling edge
    always @(negedge clk) begin
        if (!rst) begin
            obs_kind = {xfer_complete, block_gap_event, timeout_err, crc_err};
            if (obs_kind != 4'b0000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {12'h0, obs_kind, blocks_done}, 32'h0);
                end else begin
                    exp_ev = sb.pop_front();
                    chk("event", {12'h0, obs_kind, blocks_done}, {12'h0, exp_ev});
                end
            end
        end
    end

    task automatic start_xfer(input bit multi, input bit en, input int cnt);
        multi_block    = multi;
        block_count_en = en;
        block_count    = cnt[15:0];
        start = 1; tick(); start = 0;
    endtask

    task automatic pulse_start_bit();
        rx_start_bit = 1; tick(); rx_start_bit = 0;
    endtask

    task automatic pulse_done(input bit ok);
        rx_done = 1; rx_crc_ok = ok; tick(); rx_done = 0; rx_crc_ok = 0;
    endtask

    task automatic good_block();
        tick(2);
        pulse_start_bit();
        tick(4);
        pulse_done(1'b1);
    endtask

    task automatic sb_drained(input string tag);
        tick(2);
        chk(tag, sb.size(), 0);
    endtask

    initial begin
        // Reset state
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_tr", timeout_running, 0);
        chk("rst_pause", clk_pause, 0);
        chk("rst_blocks", blocks_done, 0);
        chk("rst_events", {xfer_complete, block_gap_event, timeout_err, crc_err}, 0);
        rst = 0;
        tick(2);

        // Single block
        start_xfer(0, 0, 0);
        chk("sb_busy", busy, 1);
        chk("sb_tr_wait", timeout_running, 1);
        tick(2);
        pulse_start_bit();
        chk("sb_tr_recv", timeout_running, 0);
        tick(19);
        sb.push_back({EV_CMP, 16'd1});
        pulse_done(1);
        chk("sb_busy_low", busy, 0);
        chk("sb_blocks", blocks_done, 1);
        sb_drained("sb_single");

        // Multi-block, count 3
        start_xfer(1, 1, 3);
        for (int i = 1; i <= 3; i++) begin
            if (i == 3) sb.push_back({EV_CMP, 16'd3});
            good_block();
            chk("mb_blocks", blocks_done, i);
            if (i < 3) begin
                chk("mb_gap_tr_low", timeout_running, 0);
                chk("mb_gap_busy", busy, 1);
                tick();
                chk("mb_tr_back", timeout_running, 1);
            end
        end
        chk("mb_busy_low", busy, 0);
        sb_drained("mb_three");

        // Timeout while waiting for a start bit
        start_xfer(0, 0, 0);
        tick(49);
        sb.push_back({EV_TO, 16'd0});
        timeout = 1; tick(); timeout = 0;
        chk("to_busy", busy, 0);
        chk("to_tr", timeout_running, 0);
        sb_drained("to_event");

        // Start bit and timeout in the same cycle: start bit wins
        start_xfer(0, 0, 0);
        tick(3);
        rx_start_bit = 1; timeout = 1; tick(); rx_start_bit = 0; timeout = 0;
        chk("tie_busy", busy, 1);
        chk("tie_tr", timeout_running, 0);
        tick(3);
        sb.push_back({EV_CMP, 16'd1});
        pulse_done(1);
        sb_drained("tie_complete");

        // CRC error on block 2 of 4
        start_xfer(1, 1, 4);
        good_block();
        tick();
        pulse_start_bit();
        tick(3);
        sb.push_back({EV_CRC, 16'd1});
        pulse_done(0);
        chk("crc_blocks", blocks_done, 1);
        chk("crc_busy", busy, 0);
        sb_drained("crc_event");

        // Read wait: buffer not ready after block 1 of 2
        start_xfer(1, 1, 2);
        buffer_ready = 0;
        good_block();
        tick();
        chk("rw_pause", clk_pause, 1);
        tick(3);
        chk("rw_pause_hold", clk_pause, 1);
        chk("rw_tr_low", timeout_running, 0);
        buffer_ready = 1;
        tick();
        chk("rw_pause_off", clk_pause, 0);
        chk("rw_tr_on", timeout_running, 1);
        sb.push_back({EV_CMP, 16'd2});
        good_block();
        sb_drained("rw_complete");

        // Stop at block gap, then continue
        stop_at_gap = 1;
        start_xfer(1, 1, 2);
        good_block();
        sb.push_back({EV_GAP, 16'd1});
        tick();
        chk("gs_pause", clk_pause, 1);
        stop_at_gap = 0;
        tick(3);
        chk("gs_still_stopped", clk_pause, 1);
        chk("gs_busy", busy, 1);
        continue_s = 1; tick(); continue_s = 0;
        chk("gs_resume_pause", clk_pause, 0);
        chk("gs_resume_tr", timeout_running, 1);
        sb.push_back({EV_CMP, 16'd2});
        good_block();
        sb_drained("gs_complete");

        // Abort in RECEIVE, overriding a simultaneous good rx_done
        start_xfer(1, 1, 3);
        good_block();
        tick();
        pulse_start_bit();
        tick(2);
        abort_s = 1; rx_done = 1; rx_crc_ok = 1;
        tick();
        abort_s = 0; rx_done = 0; rx_crc_ok = 0;
        chk("ab_busy", busy, 0);
        chk("ab_tr", timeout_running, 0);
        chk("ab_pause", clk_pause, 0);
        chk("ab_blocks_hold", blocks_done, 1);
        sb_drained("ab_no_event");

        // Unlimited transfer: blocks counted, no completion, then abort
        start_xfer(1, 0, 1);
        good_block();
        tick();
        good_block();
        chk("ul_blocks", blocks_done, 2);
        chk("ul_busy", busy, 1);
        abort_s = 1; tick(); abort_s = 0;
        sb_drained("ul_no_event");

        // Reset mid-transfer
        start_xfer(1, 1, 3);
        good_block();
        tick();
        rst = 1;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_tr", timeout_running, 0);
        chk("mr_blocks", blocks_done, 0);
        tick(2);
        rst = 0;
        tick();

        // Count 0 start: immediate completion, stays idle
        sb.push_back({EV_CMP, 16'd0});
        start_xfer(1, 1, 0);
        chk("z_busy", busy, 0);
        chk("z_tr", timeout_running, 0);
        sb_drained("z_complete");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
